// File: rtl/kgp_pkg.sv
// Shared definitions for the fetch sequencer: sequencer state encoding,
// default PC/instruction width, default return-stack depth and the packed
// execute-outcome flags sampled when execute completes.
package kgp_pkg;

  localparam int unsigned KGP_SIZE     = 32;
  localparam int unsigned KGP_RS_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    UPDATE = 3'd4,
    HALT   = 3'd5
  } seq_state_e;

  // Control-flow outcome reported by execute alongside ex_done
  typedef struct packed {
    logic br_taken;
    logic is_call;
    logic is_ret;
    logic halt_req;
  } ex_flags_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of all sequencer-facing signals (instruction memory, PC, decode and
// execute handshake).
//   master : the fetch sequencer (drives imem_req, instr, strobes, status)
//   slave  : the surrounding core / memory (drives acks, data, exec outcome)
interface fetch_sequencer_if
  import kgp_pkg::*;
#(
  parameter int unsigned size = KGP_SIZE
);

  logic            imem_req;
  logic            imem_ack;
  logic [size-1:0] imem_data;
  logic [size-1:0] pc;
  logic [size-1:0] instr;
  logic            instr_valid;
  logic            ex_done;
  logic            br_taken;
  logic [size-1:0] br_target;
  logic            is_call;
  logic            is_ret;
  logic            halt_req;
  logic            pc_advance;
  logic            pc_load;
  logic [size-1:0] pc_next;
  logic            halted;
  logic            rs_overflow;

  modport master (
    output imem_req, instr, instr_valid, pc_advance, pc_load, pc_next,
           halted, rs_overflow,
    input  imem_ack, imem_data, pc, ex_done, br_taken, br_target,
           is_call, is_ret, halt_req
  );

  modport slave (
    input  imem_req, instr, instr_valid, pc_advance, pc_load, pc_next,
           halted, rs_overflow,
    output imem_ack, imem_data, pc, ex_done, br_taken, br_target,
           is_call, is_ret, halt_req
  );

endinterface

// File: rtl/return_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; push and pop together replace the top entry.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (clears pointer/count)
//   push_i, pop_i  : push push_data_i / pop top entry (pop ignored when empty)
//   push_data_i    : value to push
//   data_c         : current top entry (combinational)
//   empty_c,full_c : occupancy flags (combinational)
module return_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] data_c,
  output logic             empty_c,
  output logic             full_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop_c;

  assign top_ptr_c = wr_ptr_q - PTR_W'(1);
  assign data_c    = mem_q[top_ptr_c];
  assign empty_c   = (cnt_q == '0);
  assign full_c    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop_c  = pop_i && !empty_c;

  // Pointer/count update; count saturates at DEPTH as the oldest entry is lost
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push_i && !do_pop_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!full_c) cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop_c && !push_i) begin
      wr_ptr_d = top_ptr_c;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while the count covers them
  always_ff @(posedge clk) begin
    if (!reset && push_i) begin
      if (do_pop_c) mem_q[top_ptr_c] <= push_data_i;
      else          mem_q[wr_ptr_q]  <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute/update sequencer. Requests a word from instruction
// memory, presents it to decode/execute, then issues a one-cycle PC update
// strobe selecting increment, branch target or popped return address.
// Optional return stack: define KGP_RETURN_STACK_EN to build it; otherwise
// is_call/is_ret are ignored and rs_overflow stays 0.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_sequencer_if.master (imem handshake, pc, instr,
//                execute outcome, pc_advance/pc_load/pc_next, halted,
//                rs_overflow)
module fetch_sequencer
  import kgp_pkg::*;
#(
  parameter int unsigned size     = KGP_SIZE,
  parameter int unsigned RS_DEPTH = KGP_RS_DEPTH
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  seq_state_e      state_q, state_d;
  ex_flags_t       flags_c;
  logic            ex_fire_c;
  logic [size-1:0] ret_addr_c;

  logic            imem_req_q,    imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            pc_advance_q,  pc_advance_d;
  logic            pc_load_q,     pc_load_d;
  logic            halted_q,      halted_d;
  logic            rs_overflow_q, rs_overflow_d;
  logic            halt_pend_q,   halt_pend_d;
  logic [size-1:0] instr_q,       instr_d;
  logic [size-1:0] pc_next_q,     pc_next_d;

  logic            ret_hit_c;
  logic            rs_ovf_set_c;
  logic [size-1:0] rs_data_c;

  assign flags_c = '{br_taken: bus.br_taken, is_call: bus.is_call,
                     is_ret: bus.is_ret, halt_req: bus.halt_req};
  assign ex_fire_c  = (state_q == EXEC) && bus.ex_done;
  assign ret_addr_c = bus.pc + size'(1);

`ifdef KGP_RETURN_STACK_EN
  logic rs_push_c, rs_pop_c, rs_empty_c, rs_full_c;

  // Stack is updated on the edge that enters UPDATE, using the ex_done-cycle sample
  assign ret_hit_c    = flags_c.is_ret && !rs_empty_c;
  assign rs_pop_c     = ex_fire_c && ret_hit_c;
  assign rs_push_c    = ex_fire_c && flags_c.is_call && flags_c.br_taken;
  assign rs_ovf_set_c = rs_push_c && rs_full_c && !rs_pop_c;

  return_stack #(
    .WIDTH (size),
    .DEPTH (RS_DEPTH)
  ) u_return_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rs_push_c),
    .pop_i       (rs_pop_c),
    .push_data_i (ret_addr_c),
    .data_c      (rs_data_c),
    .empty_c     (rs_empty_c),
    .full_c      (rs_full_c)
  );
`else
  logic unused_rs;

  assign ret_hit_c    = 1'b0;
  assign rs_ovf_set_c = 1'b0;
  assign rs_data_c    = '0;
  assign unused_rs    = ^{flags_c.is_call, flags_c.is_ret, ret_addr_c, 32'(RS_DEPTH)};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (bus.imem_ack) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    if (bus.ex_done) state_d = UPDATE;
      UPDATE:  state_d = halt_pend_q ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on the state being entered
  always_comb begin
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == DECODE) || (state_d == EXEC);
    pc_advance_d  = (state_d == UPDATE);
    halted_d      = (state_d == HALT);
    instr_d       = instr_q;
    pc_load_d     = 1'b0;
    pc_next_d     = '0;
    halt_pend_d   = halt_pend_q;
    rs_overflow_d = rs_overflow_q | rs_ovf_set_c;

    if ((state_q == FETCH) && bus.imem_ack) instr_d = bus.imem_data;

    // Redirect priority: return address, then branch target, else increment
    if (ex_fire_c) begin
      halt_pend_d = flags_c.halt_req;
      if (ret_hit_c) begin
        pc_load_d = 1'b1;
        pc_next_d = rs_data_c;
      end else if (flags_c.br_taken) begin
        pc_load_d = 1'b1;
        pc_next_d = bus.br_target;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_advance_q  <= 1'b0;
      pc_load_q     <= 1'b0;
      halted_q      <= 1'b0;
      rs_overflow_q <= 1'b0;
      halt_pend_q   <= 1'b0;
      instr_q       <= '0;
      pc_next_q     <= '0;
    end else begin
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      pc_advance_q  <= pc_advance_d;
      pc_load_q     <= pc_load_d;
      halted_q      <= halted_d;
      rs_overflow_q <= rs_overflow_d;
      halt_pend_q   <= halt_pend_d;
      instr_q       <= instr_d;
      pc_next_q     <= pc_next_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc_advance  = pc_advance_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.pc_next     = pc_next_q;
  assign bus.halted      = halted_q;
  assign bus.rs_overflow = rs_overflow_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; expected values are
// hand-computed per vector. Works with or without KGP_RETURN_STACK_EN.
module tb_fetch_sequencer;

  logic clk;
  logic reset;

  fetch_sequencer_if #(.size(32)) bus ();

  fetch_sequencer #(.size(32), .RS_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef KGP_RETURN_STACK_EN
  localparam bit RS_ON = 1'b1;
`else
  localparam bit RS_ON = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'd0;
    bus.ex_done   = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 32'd0;
    bus.is_call   = 1'b0;
    bus.is_ret    = 1'b0;
    bus.halt_req  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".ctl"}, 32'({bus.imem_req, bus.pc_advance, bus.pc_load,
                                 bus.instr_valid, bus.halted, bus.rs_overflow}), 32'd0);
    check_eq({tag, ".pc_next"}, bus.pc_next, 32'd0);
    check_eq({tag, ".instr"}, bus.instr, 32'd0);
  endtask

  // Answers the fetch after ack_dly cycles of imem_req; returns at the DECODE sample point
  task automatic do_fetch(input string tag, input logic [31:0] word, input int unsigned ack_dly);
    int unsigned n = 0;
    int unsigned guard = 0;
    while (!bus.imem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, ".req_seen"}, 32'(bus.imem_req), 32'd1);
    while (bus.imem_req && n < 40) begin
      n++;
      if (n == ack_dly) begin
        bus.imem_data = word;
        bus.imem_ack  = 1'b1;
      end
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    check_eq({tag, ".req_cycles"}, n, ack_dly);
    check_eq({tag, ".instr"}, bus.instr, word);
    check_eq({tag, ".valid_dec"}, 32'(bus.instr_valid), 32'd1);
  endtask

  // One full instruction; ex_wait extra EXEC cycles carry a stray imem_ack
  task automatic run_instr(input string tag, input logic [31:0] pc_val, input logic [31:0] word,
                           input int unsigned ack_dly, input int unsigned ex_wait,
                           input logic bt, input logic [31:0] tgt, input logic call,
                           input logic ret, input logic halt,
                           input logic exp_pl, input logic [31:0] exp_pn);
    bus.pc = pc_val;
    do_fetch(tag, word, ack_dly);
    @(negedge clk);
    for (int i = 0; i < int'(ex_wait); i++) begin
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    check_eq({tag, ".exec"}, 32'({bus.imem_req, bus.instr_valid, bus.pc_advance}), 32'b010);
    check_eq({tag, ".instr_hold"}, bus.instr, word);
    bus.ex_done   = 1'b1;
    bus.br_taken  = bt;
    bus.br_target = tgt;
    bus.is_call   = call;
    bus.is_ret    = ret;
    bus.halt_req  = halt;
    @(negedge clk);
    clear_inputs();
    check_eq({tag, ".update"}, 32'({bus.pc_advance, bus.pc_load, bus.instr_valid}),
             32'({1'b1, exp_pl, 1'b0}));
    check_eq({tag, ".pc_next"}, bus.pc_next, exp_pn);
    @(negedge clk);
    check_eq({tag, ".strobe_off"}, 32'({bus.pc_advance, bus.pc_load}), 32'd0);
    check_eq({tag, ".pc_next_off"}, bus.pc_next, 32'd0);
    check_eq({tag, ".after"}, 32'({bus.imem_req, bus.halted}), halt ? 32'b01 : 32'b10);
  endtask

  initial begin
    int unsigned bad;
    reset  = 1'b1;
    bus.pc = 32'd0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_to_fetch", 32'(bus.imem_req), 32'd1);

    run_instr("seq",          32'h0000_0000, 32'h1111_1111, 3, 0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run_instr("br",           32'h0000_0004, 32'h2222_2222, 1, 0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    run_instr("ret_empty",    32'h0000_0040, 32'h3333_3333, 2, 3, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    run_instr("ret_empty_br", 32'h0000_0041, 32'h4444_4444, 1, 0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44);

    run_instr("call", 32'h0000_0010, 32'h5555_0001, 1, 0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
    run_instr("ret",  32'h0000_0080, 32'h5555_0002, 1, 0, 1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 1'b1,
              RS_ON ? 32'h11 : 32'h99);

    for (int i = 1; i <= 5; i++) begin
      run_instr($sformatf("nest_call%0d", i), 32'(i) << 8, 32'h6666_0000 + 32'(i), 1, 0,
                1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i));
      if (i == 4) check_eq("ovf_at4", 32'(bus.rs_overflow), 32'd0);
    end
    check_eq("ovf_at5", 32'(bus.rs_overflow), 32'(RS_ON));
    for (int i = 5; i >= 2; i--) begin
      run_instr($sformatf("nest_ret%0d", i), 32'h2000, 32'h7777_0000 + 32'(i), 1, 0,
                1'b0, 32'h0, 1'b0, 1'b1, 1'b0, RS_ON, RS_ON ? ((32'(i) << 8) + 32'd1) : 32'd0);
    end
    run_instr("ret_drained", 32'h2000, 32'h7777_0001, 1, 0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("ovf_sticky", 32'(bus.rs_overflow), 32'(RS_ON));

    // Reset in EXEC with a pending push on the stack and competing inputs
    run_instr("call2", 32'h30, 32'h8888_0001, 1, 0, 1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60);
    bus.pc = 32'h60;
    do_fetch("rst_fetch", 32'h8888_0002, 2);
    @(negedge clk);
    check_eq("rst.in_exec", 32'(bus.instr_valid), 32'd1);
    reset         = 1'b1;
    bus.ex_done   = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h77;
    bus.halt_req  = 1'b1;
    bus.imem_ack  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    check_all_zero("rst_exec");
    @(negedge clk);
    check_eq("rst.refetch", 32'(bus.imem_req), 32'd1);
    run_instr("rst_ret", 32'h60, 32'h9999_0001, 1, 0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("rst.ovf_clear", 32'(bus.rs_overflow), 32'd0);

    // Halt with a redirect, then stay halted despite stray inputs
    run_instr("halt", 32'h70, 32'hAAAA_0001, 2, 0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.imem_ack = 1'b1;
      bus.ex_done  = 1'b1;
      @(negedge clk);
      if (bus.imem_req || !bus.halted || bus.pc_advance || bus.pc_load || bus.instr_valid) bad++;
    end
    clear_inputs();
    check_eq("halt.hold_bad_cycles", bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter size, default 32, meaning PC/instruction/target width.
REQ-002 SHALL have parameter RS_DEPTH, default 4, meaning return-stack entries (power of 2).
REQ-003 SHALL have ports clk in 1 system clock; reset in 1 synchronous active-high reset.
REQ-004 SHALL have ports imem_req out 1 fetch request; imem_ack in 1 fetch data valid; imem_data in size fetched word.
REQ-005 SHALL have ports pc in size current PC; instr out size latched instruction; instr_valid out 1 instr usable by decode/execute.
REQ-006 SHALL have ports ex_done in 1 execute complete; br_taken in 1 redirect; br_target in size redirect address; is_call in 1; is_ret in 1; halt_req in 1.
REQ-007 SHALL have ports pc_advance out 1 single-cycle PC update strobe; pc_load out 1 load-vs-increment select; pc_next out size load value; halted out 1; rs_overflow out 1 sticky.

Function
REQ-008 SHALL implement states IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
REQ-009 SHALL move IDLE->FETCH the cycle after reset deasserts.
REQ-010 SHALL hold imem_req high throughout FETCH, low in every other state.
REQ-011 SHALL, in FETCH with imem_ack=1, latch imem_data into instr and go to DECODE next cycle; imem_ack outside FETCH SHALL be ignored.
REQ-012 SHALL spend exactly one cycle in DECODE, then enter EXEC; instr_valid SHALL be high in DECODE and EXEC only.
REQ-013 SHALL stay in EXEC until ex_done=1, then sample br_taken, br_target, is_call, is_ret, halt_req in that cycle and enter UPDATE.
REQ-014 SHALL assert pc_advance for exactly one cycle in UPDATE, then enter FETCH, or HALT if halt_req was sampled.
REQ-015 SHALL select the UPDATE value by priority: is_ret with non-empty stack -> pc_load=1, pc_next=popped entry; else br_taken -> pc_load=1, pc_next=br_target; else pc_load=0 (increment).
REQ-016 SHALL, with is_call and br_taken sampled, push pc+1 (modulo 2^size) in UPDATE.
REQ-017 SHALL, on push when full, drop the oldest entry, keep the new one and set rs_overflow; on is_ret when empty, fall through to REQ-015's lower priorities.
REQ-018 SHALL drive pc_load=0 and pc_next=0 whenever pc_advance=0.
REQ-019 SHALL remain in HALT with halted=1, and all strobes low, until reset.
REQ-020 SHALL give halt_req priority over nothing else: the final UPDATE still performs its redirect before HALT.

Reset
REQ-021 SHALL, on reset=1 at a clk rising edge in any state (including mid-FETCH and mid-EXEC), enter IDLE and clear imem_req, pc_advance, pc_load, pc_next, instr, instr_valid, halted, rs_overflow, and the stack pointer.
REQ-022 SHALL take reset priority over every other input in the same cycle.

Configuration
REQ-023 SHALL compile the return stack only when macro KGP_RETURN_STACK_EN is defined.
REQ-024 SHALL, without KGP_RETURN_STACK_EN, ignore is_call/is_ret (treat ret as ordinary br_taken/increment), tie rs_overflow to 0, and keep all other behaviour identical.

Structure
REQ-025 SHALL take state encodings and the default width constant from shared package kgp_pkg.
REQ-026 SHALL place the return stack in sub-module return_stack (push, pop, data, empty, full).

Verification
REQ-027 SHALL cover: reset, imem_ack after 3 cycles, ex_done, br_taken=0 -> one pc_advance with pc_load=0, FETCH re-entered; imem_req high exactly 3 cycles.
REQ-028 SHALL cover: br_taken=1, br_target=0x40 -> pc_advance=1, pc_load=1, pc_next=0x40 for one cycle.
REQ-029 SHALL cover (macro on): call at pc=0x10 to 0x80, then ret -> second UPDATE pc_next=0x11; 5 nested calls with RS_DEPTH=4 -> rs_overflow=1, 4 rets return most recent 4 addresses.
REQ-030 SHALL cover: reset asserted mid-EXEC -> next cycle IDLE, all outputs 0, stack empty.
REQ-031 SHALL cover: halt_req with br_taken to 0x20 -> pc_next=0x20 strobe, then halted=1 and imem_req stays 0 for 10 cycles.
REQ-032 SHALL cover: imem_ack pulsed in EXEC -> instr unchanged.
